div_unit: RTL

- Multi-cycle 32-bit integer divider for DIV/DIVU. It is the HI/LO producer on the execute side of the pipeline.
- Execute stage issues start with rs/rt. The unit stalls the pipeline while iterating, then returns {HI=remainder, LO=quotient} for the HI/LO write path, alongside the single-cycle ALU HI/LO outputs.
- Radix-2 restoring algorithm, one quotient bit per clock.

---
 rtl/div_unit.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider for DIV / DIVU.
//
// It produces {HI = remainder, LO = quotient} for the HI/LO write path and
// holds the pipeline while it iterates, one quotient bit per clock.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   signed_div in   1 = DIV (signed), 0 = DIVU; sampled with start
//   opdata1    in   dividend (rs); sampled with start
//   opdata2    in   divisor (rt); sampled with start
//   start      in   divide request, accepted only while idle
//   annul      in   cancel (exception / flush), overrides everything else
//   result     out  {remainder, quotient}; valid while ready = 1, held afterwards
//   ready      out  one-cycle completion pulse
//   stall_div  out  combinational pipeline stall request
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               start,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall_div
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } state_t;

  // Two's-complement negation at operand width.
  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
    neg = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; unsigned operands pass through untouched.
  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      mag = neg(v);
    end else begin
      mag = v;
    end
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   dvd_r;      // dividend magnitude, shifted out MSB first
  logic [WIDTH:0]     dsr_r;      // divisor magnitude, one extra bit of headroom
  logic [WIDTH:0]     rem_r;      // partial remainder
  logic [WIDTH-1:0]   quo_r;      // quotient bits shifted in LSB first
  logic [CW-1:0]      cnt_r;
  logic               quo_neg_r;
  logic               rem_neg_r;
  logic [2*WIDTH-1:0] result_r;
  logic               ready_r;

  logic               accept_s;
  logic               op1_neg_s;
  logic               op2_neg_s;
  logic [WIDTH+1:0]   partial_s;
  logic [WIDTH+1:0]   diff_s;
  logic               qbit_s;
  logic [WIDTH:0]     rem_nxt_s;
  logic [WIDTH-1:0]   quo_nxt_s;
  logic [WIDTH-1:0]   rem_low_s;
  logic [WIDTH-1:0]   quo_fix_s;
  logic [WIDTH-1:0]   rem_fix_s;

  // One restoring step: trial-subtract the divisor from the shifted remainder.
  always_comb begin
    accept_s  = (state_r == IDLE) && start && !annul;
    op1_neg_s = signed_div && opdata1[WIDTH-1];
    op2_neg_s = signed_div && opdata2[WIDTH-1];
    partial_s = {rem_r, dvd_r[WIDTH-1]};
    diff_s    = partial_s - {1'b0, dsr_r};
    // A clear top bit means the trial subtraction did not borrow.
    qbit_s    = ~diff_s[WIDTH+1];
    if (qbit_s) begin
      rem_nxt_s = diff_s[WIDTH:0];
    end else begin
      rem_nxt_s = partial_s[WIDTH:0];
    end
    quo_nxt_s = {quo_r[WIDTH-2:0], qbit_s};
    rem_low_s = rem_nxt_s[WIDTH-1:0];
    // Quotient sign is op1^op2; remainder follows the dividend's sign.
    quo_fix_s = quo_neg_r ? neg(quo_nxt_s) : quo_nxt_s;
    rem_fix_s = rem_neg_r ? neg(rem_low_s) : rem_low_s;
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and stall request.
  always_comb begin
    state_nxt_s = state_r;
    stall_div   = accept_s || (state_r == ON) || (state_r == DIVZERO);
    if (annul) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nxt_s = (opdata2 == {WIDTH{1'b0}}) ? DIVZERO : ON;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        DIVZERO: state_nxt_s = END;
        ON: begin
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = END;
          end else begin
            state_nxt_s = ON;
          end
        end
        END:     state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_r     <= {WIDTH{1'b0}};
      dsr_r     <= {(WIDTH+1){1'b0}};
      rem_r     <= {(WIDTH+1){1'b0}};
      quo_r     <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      quo_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      result_r  <= {(2*WIDTH){1'b0}};
      ready_r   <= 1'b0;
    end else begin
      // ready marks exactly the cycle spent in END; annul never reaches END.
      ready_r <= (state_nxt_s == END);
      case (state_r)
        IDLE: begin
          if (accept_s && (opdata2 != {WIDTH{1'b0}})) begin
            dvd_r     <= mag(opdata1, signed_div);
            dsr_r     <= {1'b0, mag(opdata2, signed_div)};
            rem_r     <= {(WIDTH+1){1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            cnt_r     <= {CW{1'b0}};
            rem_neg_r <= op1_neg_s;
            quo_neg_r <= op1_neg_s ^ op2_neg_s;
          end
        end
        ON: begin
          if (!annul) begin
            dvd_r <= {dvd_r[WIDTH-2:0], 1'b0};
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r + CW'(1);
            if (cnt_r == CNT_LAST) begin
              result_r <= {rem_fix_s, quo_fix_s};
            end
          end
        end
        DIVZERO: begin
          // Divide-by-zero result is architecturally unpredictable; pin it to 0.
          if (!annul) begin
            result_r <= {(2*WIDTH){1'b0}};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result = result_r;
  assign ready  = ready_r;

endmodule
